nios_cpu_ram_arbiter: RTL and testbench

- Sequences and shares the Nios on-chip single-port RAM (64K x 32, byte-enabled, 1-cycle read latency) between two Avalon-MM masters: m0 (CPU data master) and m1 (DMA/debug).
- After reset, optionally zero-fills the whole RAM before granting any master access.
- Issues at most one RAM command per cycle; pipelined reads; round-robin fairness.

---
 rtl/nios_cpu_ram_arbiter.sv | 157 +++++++++++++++
 tb/tb_nios_cpu_ram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_cpu_ram_arbiter.sv
// Shares the Nios single-port on-chip RAM between two Avalon-MM masters,
// with an optional zero-fill sweep after reset before any master is granted.
module nios_cpu_ram_arbiter #(
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned BE_W           = 4,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              reset_n,

   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,

   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,

   output logic [ADDR_W-1:0] ram_address,
   output logic [BE_W-1:0]   ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   output logic              ram_clken,
   input  logic [DATA_W-1:0] ram_readdata,

   output logic              init_done
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   fill_cnt;
   logic [CNT_W-1:0]   fill_nxt;
   logic               last_grant;   // 0 = m0, 1 = m1
   logic               rd_pend;
   logic               rd_owner;

   logic               req0;
   logic               req1;
   logic               running;
   logic               clearing;
   logic               gnt0;
   logic               gnt1;
   logic               rd_accept;

   assign ram_clken = 1'b1;
   assign fill_nxt  = fill_cnt + CNT_W'(1);

   // Round-robin grant: on contention the master not served last wins.
   always_comb begin
      req0      = m0_read | m0_write;
      req1      = m1_read | m1_write;
      running   = reset_n & (state == ST_RUN);
      clearing  = reset_n & (state == ST_CLEAR);
      gnt0      = running & req0 & (~req1 | last_grant);
      gnt1      = running & req1 & (~req0 | ~last_grant);
      rd_accept = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);
   end

   // RAM command mux and stall generation.
   always_comb begin
      ram_address    = '0;
      ram_byteenable = '0;
      ram_chipselect = 1'b0;
      ram_write      = 1'b0;
      ram_writedata  = '0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;

      if (running) begin
         m0_waitrequest = req0 & ~gnt0;
         m1_waitrequest = req1 & ~gnt1;
      end

      if (clearing) begin
         ram_address    = fill_cnt[ADDR_W-1:0];
         ram_byteenable = '1;
         ram_chipselect = 1'b1;
         ram_write      = 1'b1;
      end else if (gnt0) begin
         ram_address    = m0_address;
         ram_byteenable = m0_byteenable;
         ram_chipselect = 1'b1;
         ram_write      = m0_write;
         ram_writedata  = m0_writedata;
      end else if (gnt1) begin
         ram_address    = m1_address;
         ram_byteenable = m1_byteenable;
         ram_chipselect = 1'b1;
         ram_write      = m1_write;
         ram_writedata  = m1_writedata;
      end
   end

   // RAM q is shared; the owner tag decides who sees the valid strobe.
   assign m0_readdata      = ram_readdata;
   assign m1_readdata      = ram_readdata;
   assign m0_readdatavalid = reset_n & rd_pend & ~rd_owner;
   assign m1_readdatavalid = reset_n & rd_pend & rd_owner;

   // Sequencer: fill sweep, then RUN until the next reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_START;
         fill_cnt   <= '0;
         init_done  <= 1'b0;
         last_grant <= 1'b1;
         rd_pend    <= 1'b0;
         rd_owner   <= 1'b0;
      end else begin
         rd_pend  <= rd_accept;
         rd_owner <= gnt1;
         if (gnt0 | gnt1) begin
            last_grant <= gnt1;
         end
         case (state)
            ST_CLEAR: begin
               fill_cnt <= fill_nxt;
               // Counter MSB flags that the last address has been written.
               if (fill_nxt[ADDR_W]) begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
               end
            end
            ST_START: begin
               state     <= ST_RUN;
               init_done <= 1'b1;
            end
            ST_RUN: begin
               state <= ST_RUN;
            end
            default: begin
               state <= ST_CLEAR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nios_cpu_ram_arbiter.sv
// Bench for nios_cpu_ram_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_nios_cpu_ram_arbiter;

   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 32;
   localparam int unsigned BW    = 4;
   localparam int unsigned DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AW-1:0] m0_address, m1_address;
   logic [BW-1:0] m0_byteenable, m1_byteenable;
   logic          m0_read, m0_write, m1_read, m1_write;
   logic [DW-1:0] m0_writedata, m1_writedata;
   logic          m0_waitrequest, m1_waitrequest;
   logic [DW-1:0] m0_readdata, m1_readdata;
   logic          m0_readdatavalid, m1_readdatavalid;
   logic [AW-1:0] ram_address;
   logic [BW-1:0] ram_byteenable;
   logic          ram_chipselect, ram_write, ram_clken;
   logic [DW-1:0] ram_writedata;
   logic [DW-1:0] ram_readdata = '0;
   logic          init_done;

   int checks = 0;
   int errors = 0;

   nios_cpu_ram_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .CLEAR_ON_RESET(1)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable),
      .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable),
      .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_chipselect(ram_chipselect), .ram_write(ram_write),
      .ram_writedata(ram_writedata), .ram_clken(ram_clken),
      .ram_readdata(ram_readdata), .init_done(init_done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] be_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
      return m;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // RAM fixture: byte-enabled, one-cycle read latency, garbage before fill.
   logic [31:0] fmem [DEPTH];
   logic        fmem_init = 1'b1;
   always @(posedge clk) begin
      if (fmem_init) begin
         for (int i = 0; i < DEPTH; i++) fmem[i] <= 32'hA5A5_0000 | 32'(i);
         fmem_init <= 1'b0;
      end else if (ram_clken && ram_chipselect) begin
         if (ram_write)
            fmem[ram_address] <= (fmem[ram_address] & ~be_mask(ram_byteenable)) |
                                 (ram_writedata & be_mask(ram_byteenable));
         else
            ram_readdata <= fmem[ram_address];
      end
   end

   // Reference model: fill progress, last winner, one pending read, memory image.
   int          m_fill = 0;
   bit          m_run  = 1'b0;
   bit          m_last = 1'b1;
   bit          m_pv   = 1'b0;
   bit          m_po   = 1'b0;
   logic [31:0] m_pd   = '0;
   logic [31:0] mmem [DEPTH];

   always @(negedge clk) begin
      bit          rq [2];
      bit          rd [2];
      bit          wr [2];
      logic [3:0]  ad [2];
      logic [3:0]  be [2];
      logic [31:0] wd [2];
      int          g;
      bit          ew0, ew1, ecs, ewe;
      logic [3:0]  eaddr, ebe;
      logic [31:0] ewd;

      rd[0] = m0_read;  wr[0] = m0_write;  ad[0] = m0_address;
      be[0] = m0_byteenable;  wd[0] = m0_writedata;
      rd[1] = m1_read;  wr[1] = m1_write;  ad[1] = m1_address;
      be[1] = m1_byteenable;  wd[1] = m1_writedata;
      rq[0] = rd[0] | wr[0];
      rq[1] = rd[1] | wr[1];

      g = -1;
      ew0 = 1'b1;  ew1 = 1'b1;  ecs = 1'b0;  ewe = 1'b0;
      eaddr = '0;  ebe = '0;  ewd = '0;
      if (reset_n && !m_run) begin
         ecs = 1'b1;  ewe = 1'b1;  eaddr = 4'(m_fill);  ebe = 4'hF;
      end else if (reset_n && m_run) begin
         if (rq[0] && rq[1]) g = m_last ? 0 : 1;
         else if (rq[0])     g = 0;
         else if (rq[1])     g = 1;
         ew0 = rq[0] && (g != 0);
         ew1 = rq[1] && (g != 1);
         if (g >= 0) begin
            ecs = 1'b1;  ewe = wr[g];  eaddr = ad[g];  ebe = be[g];  ewd = wd[g];
         end
      end

      chk("m0_waitrequest", 32'(m0_waitrequest), 32'(ew0));
      chk("m1_waitrequest", 32'(m1_waitrequest), 32'(ew1));
      chk("ram_chipselect", 32'(ram_chipselect), 32'(ecs));
      chk("ram_clken", 32'(ram_clken), 32'd1);
      chk("init_done", 32'(init_done), 32'(m_run));
      chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(reset_n && m_pv && !m_po));
      chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(reset_n && m_pv && m_po));
      if (reset_n && m_pv) chk(m_po ? "m1_readdata" : "m0_readdata",
                               m_po ? m1_readdata : m0_readdata, m_pd);
      if (ecs) begin
         chk("ram_write", 32'(ram_write), 32'(ewe));
         chk("ram_address", 32'(ram_address), 32'(eaddr));
         chk("ram_byteenable", 32'(ram_byteenable), 32'(ebe));
         if (ewe) chk("ram_writedata", ram_writedata, ewd);
      end

      // Advance to the state seen after the coming clock edge.
      if (!reset_n) begin
         m_fill = 0;  m_run = 1'b0;  m_last = 1'b1;  m_pv = 1'b0;
      end else begin
         m_pv = 1'b0;
         if (!m_run) begin
            mmem[m_fill] = '0;
            m_fill++;
            if (m_fill == DEPTH) m_run = 1'b1;
         end else if (g >= 0) begin
            if (wr[g])
               mmem[ad[g]] = (mmem[ad[g]] & ~be_mask(be[g])) | (wd[g] & be_mask(be[g]));
            else begin
               m_pv = 1'b1;  m_po = (g == 1);  m_pd = mmem[ad[g]];
            end
            m_last = (g == 1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m0_read = 0;  m0_write = 0;  m0_address = '0;  m0_byteenable = '0;  m0_writedata = '0;
      m1_read = 0;  m1_write = 0;  m1_address = '0;  m1_byteenable = '0;  m1_writedata = '0;
   endtask

   task automatic setm(input int m, input bit r, input bit w, input int a,
                       input logic [31:0] d, input logic [3:0] b);
      if (m == 0) begin
         m0_read = r;  m0_write = w;  m0_address = 4'(a);  m0_writedata = d;  m0_byteenable = b;
      end else begin
         m1_read = r;  m1_write = w;  m1_address = 4'(a);  m1_writedata = d;  m1_byteenable = b;
      end
   endtask

   task automatic random_traffic(input int n);
      for (int c = 0; c < n; c++) begin
         idle();
         for (int m = 0; m < 2; m++) begin
            int k;
            k = int'($urandom_range(0, 9));
            if (k >= 3)
               setm(m, k < 6, k >= 6 || k == 3, int'($urandom_range(0, 15)), $urandom,
                    4'($urandom_range(0, 15)));
         end
         tick();
      end
   endtask

   initial begin
      idle();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // Fill sweep with m0 already asking for a read.
      reset_n = 1'b1;
      setm(0, 1, 0, 1, '0, 4'hF);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("fill_stall", 32'(m0_waitrequest), 32'd1);
         chk("fill_addr", 32'(ram_address), 32'(i));
         tick();
      end
      @(negedge clk);
      chk("init_done_at_16", 32'(init_done), 32'd1);
      chk("m0_grant_at_16", 32'(m0_waitrequest), 32'd0);
      tick();
      idle();

      // Single write/read.
      setm(0, 0, 1, 5, 32'hDEADBEEF, 4'hF);  tick();
      idle();  setm(0, 1, 0, 5, '0, 4'hF);   tick();
      idle();  @(negedge clk);
      chk("rd5_valid", 32'(m0_readdatavalid), 32'd1);
      chk("rd5_data", m0_readdata, 32'hDEADBEEF);
      chk("rd5_m1_quiet", 32'(m1_readdatavalid), 32'd0);
      tick();

      // Byte-lane write from m1.
      setm(1, 0, 1, 5, 32'h0000_00AA, 4'h1);  tick();
      idle();  setm(0, 1, 0, 5, '0, 4'hF);    tick();
      idle();  @(negedge clk);
      chk("byte_merge", m0_readdata, 32'hDEADBEAA);
      tick();

      // Contention: m1 served last, so m0 wins first.
      setm(0, 0, 1, 1, 32'h1111_1111, 4'hF);  tick();
      idle();  setm(1, 0, 1, 2, 32'h2222_2222, 4'hF);  tick();
      idle();
      setm(0, 1, 0, 1, '0, 4'hF);
      setm(1, 1, 0, 2, '0, 4'hF);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("cont_wait0", 32'(m0_waitrequest), 32'(k % 2));
         chk("cont_wait1", 32'(m1_waitrequest), 32'((k + 1) % 2));
         if (k > 0) begin
            chk("cont_rdv0", 32'(m0_readdatavalid), 32'((k - 1) % 2 == 0));
            chk("cont_data", m0_readdata, ((k - 1) % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
         end
         tick();
      end
      idle();  @(negedge clk);
      chk("cont_last_rdv1", 32'(m1_readdatavalid), 32'd1);
      chk("cont_last_data", m1_readdata, 32'h2222_2222);
      tick();

      // Read and write together is a write only.
      setm(0, 1, 1, 3, 32'h1234_5678, 4'hF);  tick();
      idle();  @(negedge clk);
      chk("rw_no_rdv", 32'(m0_readdatavalid), 32'd0);
      tick();
      setm(0, 1, 0, 3, '0, 4'hF);  tick();
      idle();  @(negedge clk);
      chk("rw_readback", m0_readdata, 32'h1234_5678);
      tick();

      random_traffic(400);

      // Reset with a read in flight.
      idle();  setm(0, 1, 0, 5, '0, 4'hF);  tick();
      idle();  reset_n = 1'b0;
      @(negedge clk);
      chk("rst_drop_rdv", 32'(m0_readdatavalid), 32'd0);
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_fill_addr0", 32'(ram_address), 32'd0);
      repeat (7) tick();
      // Reset lands on fill address 7.
      @(negedge clk);
      chk("fill_at7", 32'(ram_address), 32'd7);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      chk("fill_restart", 32'(ram_address), 32'd0);
      repeat (16) tick();
      @(negedge clk);
      chk("refill_done", 32'(init_done), 32'd1);
      tick();

      random_traffic(100);
      idle();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
